// File: rtl/pipelined_data_path_if.sv
// Handshake bundle for the two-stage execute datapath:
// decoded fields in, retire data out.
interface pipelined_data_path_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic            in_valid_DP;
  logic            in_ready_DP;
  logic [RAW-1:0]  A1_DP;
  logic [RAW-1:0]  A2_DP;
  logic [RAW-1:0]  A3_DP;
  logic [XLEN-1:0] ImmExt_DP;
  logic            ALUSrc_DP;
  logic [3:0]      ALUControl_DP;
  logic            RegWrite_DP;
  logic            out_valid_DP;
  logic            out_ready_DP;
  logic [XLEN-1:0] ALUResult_DP;
  logic [XLEN-1:0] RD2_DP;
  logic [RAW-1:0]  Rd_DP;
  logic            RegWriteOut_DP;
  logic            Zero_DP;
  logic            sign_flag_DP;

  modport master (
    output in_valid_DP,
    input  in_ready_DP,
    output A1_DP,
    output A2_DP,
    output A3_DP,
    output ImmExt_DP,
    output ALUSrc_DP,
    output ALUControl_DP,
    output RegWrite_DP,
    input  out_valid_DP,
    output out_ready_DP,
    input  ALUResult_DP,
    input  RD2_DP,
    input  Rd_DP,
    input  RegWriteOut_DP,
    input  Zero_DP,
    input  sign_flag_DP
  );

  modport slave (
    input  in_valid_DP,
    output in_ready_DP,
    input  A1_DP,
    input  A2_DP,
    input  A3_DP,
    input  ImmExt_DP,
    input  ALUSrc_DP,
    input  ALUControl_DP,
    input  RegWrite_DP,
    output out_valid_DP,
    input  out_ready_DP,
    output ALUResult_DP,
    output RD2_DP,
    output Rd_DP,
    output RegWriteOut_DP,
    output Zero_DP,
    output sign_flag_DP
  );
endinterface

// File: rtl/pipelined_data_path.sv
// Two-stage execute datapath: regfile + forwarding into EX,
// ALU into OUT, writeback on the output handshake.
module pipelined_data_path #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = 5
) (
  input logic CLK_DP,
  input logic reset_DP,
  input logic flush_DP,
  pipelined_data_path_if.slave dp
);

  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic            src;
    logic [3:0]      ctl;
    logic [RAW-1:0]  rd;
    logic            rw;
  } ex_t;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] rd2;
    logic [RAW-1:0]  rd;
    logic            rw;
    logic            zero;
    logic            sign;
  } out_t;

  logic [XLEN-1:0] rf [NREG];

  ex_t  ex_q;
  ex_t  ex_d;
  logic ex_valid;
  out_t out_q;
  out_t out_d;
  logic out_valid;

  logic out_adv;
  logic ex_adv;
  logic accept;
  logic retire;

  logic [XLEN-1:0] rf1;
  logic [XLEN-1:0] rf2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            ex_hit1;
  logic            ex_hit2;
  logic            out_hit1;
  logic            out_hit2;

  logic [XLEN-1:0] srcb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu;

  assign out_adv = !out_valid || dp.out_ready_DP;
  assign ex_adv  = ex_valid && out_adv;
  assign dp.in_ready_DP = (!ex_valid || out_adv) && !flush_DP;
  assign accept  = dp.in_valid_DP && dp.in_ready_DP;

  assign retire = out_valid && dp.out_ready_DP
               && out_q.rw && (out_q.rd != '0)
               && (int'(out_q.rd) < NREG) && !flush_DP;

  always_comb begin
    rf1 = '0;
    if (dp.A1_DP != '0 && int'(dp.A1_DP) < NREG)
      rf1 = rf[dp.A1_DP];
  end

  always_comb begin
    rf2 = '0;
    if (dp.A2_DP != '0 && int'(dp.A2_DP) < NREG)
      rf2 = rf[dp.A2_DP];
  end

  assign ex_hit1  = ex_valid && ex_q.rw
                 && (ex_q.rd == dp.A1_DP);
  assign ex_hit2  = ex_valid && ex_q.rw
                 && (ex_q.rd == dp.A2_DP);
  assign out_hit1 = out_valid && out_q.rw
                 && (out_q.rd == dp.A1_DP);
  assign out_hit2 = out_valid && out_q.rw
                 && (out_q.rd == dp.A2_DP);

  // EX is the youngest producer, so it wins over OUT
  always_comb begin
    op1 = rf1;
    if (dp.A1_DP == '0)  op1 = '0;
    else if (ex_hit1)    op1 = alu;
    else if (out_hit1)   op1 = out_q.res;
  end

  always_comb begin
    op2 = rf2;
    if (dp.A2_DP == '0)  op2 = '0;
    else if (ex_hit2)    op2 = alu;
    else if (out_hit2)   op2 = out_q.res;
  end

  always_comb begin
    ex_d     = '0;
    ex_d.op1 = op1;
    ex_d.op2 = op2;
    ex_d.imm = dp.ImmExt_DP;
    ex_d.src = dp.ALUSrc_DP;
    ex_d.ctl = dp.ALUControl_DP;
    ex_d.rd  = dp.A3_DP;
    ex_d.rw  = dp.RegWrite_DP;
  end

  always_comb begin
    srcb  = ex_q.src ? ex_q.imm : ex_q.op2;
    shamt = srcb[SHW-1:0];
    alu   = '0;
    unique case (ex_q.ctl)
      4'b0000: alu = ex_q.op1 + srcb;
      4'b0001: alu = ex_q.op1 - srcb;
      4'b0010: alu = ex_q.op1 & srcb;
      4'b0011: alu = ex_q.op1 | srcb;
      4'b0100: alu = ex_q.op1 ^ srcb;
      4'b0101: alu = ex_q.op1 << shamt;
      4'b0110: alu = ex_q.op1 >> shamt;
      4'b0111: alu = XLEN'($signed(ex_q.op1) >>> shamt);
      4'b1000: alu = {{(XLEN-1){1'b0}},
                      $signed(ex_q.op1) < $signed(srcb)};
      4'b1001: alu = {{(XLEN-1){1'b0}},
                      ex_q.op1 < srcb};
      default: alu = '0;
    endcase
  end

  always_comb begin
    out_d      = '0;
    out_d.res  = alu;
    out_d.rd2  = ex_q.op2;
    out_d.rd   = ex_q.rd;
    out_d.rw   = ex_q.rw;
    out_d.zero = (alu == '0);
    out_d.sign = alu[XLEN-1];
  end

  always_ff @(posedge CLK_DP or posedge reset_DP) begin
    if (reset_DP) begin
      ex_valid  <= 1'b0;
      ex_q      <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush_DP) begin
      ex_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        ex_q     <= ex_d;
        ex_valid <= 1'b1;
      end else if (ex_adv) begin
        ex_valid <= 1'b0;
      end
      if (ex_adv) begin
        out_q     <= out_d;
        out_valid <= 1'b1;
      end else if (dp.out_ready_DP) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_DP or posedge reset_DP) begin
    if (reset_DP) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (retire) begin
      rf[out_q.rd] <= out_q.res;
    end
  end

  assign dp.out_valid_DP   = out_valid;
  assign dp.ALUResult_DP   = out_q.res;
  assign dp.RD2_DP         = out_q.rd2;
  assign dp.Rd_DP          = out_q.rd;
  assign dp.RegWriteOut_DP = out_q.rw;
  assign dp.Zero_DP        = out_q.zero;
  assign dp.sign_flag_DP   = out_q.sign;

endmodule
